cls381_target_model: RTL and testbench

CLS381_TARGET_MODEL -- requirements
Module: cls381_target_model

---
 rtl/cls381_target_model_pkg.sv | 71 +++++++
 rtl/cls381_target_model_sync.sv | 37 +++
 rtl/cls381_target_model.sv | 202 ++++++++++++++++++++
 tb/tb_cls381_target_model.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cls381_target_model_pkg.sv
// Shared definitions for the CLS381 I2C colour-sensor target model:
// register map, reset values, FSM state encoding and the read-data mux.
package cls381_target_model_pkg;

    localparam logic [7:0] ADDR_MAIN_CTRL = 8'h00;
    localparam logic [7:0] ADDR_MEAS_RATE = 8'h04;
    localparam logic [7:0] ADDR_GAIN      = 8'h05;
    localparam logic [7:0] ADDR_PART_ID   = 8'h06;
    localparam logic [7:0] ADDR_STATUS    = 8'h07;
    localparam logic [7:0] ADDR_GREEN_0   = 8'h0D;
    localparam logic [7:0] ADDR_GREEN_1   = 8'h0E;
    localparam logic [7:0] ADDR_GREEN_2   = 8'h0F;
    localparam logic [7:0] ADDR_BLUE_0    = 8'h10;
    localparam logic [7:0] ADDR_BLUE_1    = 8'h11;
    localparam logic [7:0] ADDR_BLUE_2    = 8'h12;
    localparam logic [7:0] ADDR_RED_0     = 8'h13;
    localparam logic [7:0] ADDR_RED_1     = 8'h14;
    localparam logic [7:0] ADDR_RED_2     = 8'h15;

    localparam logic [7:0] PART_ID_VAL    = 8'hC2;

    localparam logic [7:0] RST_MAIN_CTRL  = 8'h00;
    localparam logic [7:0] RST_MEAS_RATE  = 8'h22;
    localparam logic [7:0] RST_GAIN       = 8'h01;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_e;

    // Colour bytes come from the snapshot, never from the live inputs.
    function automatic logic [7:0] reg_read(
        input logic [7:0]  ptr,
        input logic [7:0]  main_ctrl,
        input logic [7:0]  meas_rate,
        input logic [7:0]  gain,
        input logic        new_data,
        input logic [23:0] snap_r,
        input logic [23:0] snap_g,
        input logic [23:0] snap_b
    );
        logic [7:0] val;
        case (ptr)
            ADDR_MAIN_CTRL: val = main_ctrl;
            ADDR_MEAS_RATE: val = meas_rate;
            ADDR_GAIN:      val = gain;
            ADDR_PART_ID:   val = PART_ID_VAL;
            ADDR_STATUS:    val = {4'b0, new_data, 3'b0};
            ADDR_GREEN_0:   val = snap_g[7:0];
            ADDR_GREEN_1:   val = snap_g[15:8];
            ADDR_GREEN_2:   val = snap_g[23:16];
            ADDR_BLUE_0:    val = snap_b[7:0];
            ADDR_BLUE_1:    val = snap_b[15:8];
            ADDR_BLUE_2:    val = snap_b[23:16];
            ADDR_RED_0:     val = snap_r[7:0];
            ADDR_RED_1:     val = snap_r[15:8];
            ADDR_RED_2:     val = snap_r[23:16];
            default:        val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cls381_target_model_sync.sv
// Two-flop synchronizers for SCL/SDA with a third stage for edge, START
// and STOP detection; everything downstream uses only these outputs.
module i2c_bus_sync
    import cls381_target_model_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic scl,
    input  logic sda_in,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Idle bus level is high, so reset to 1 to avoid false edges.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign sda_sync  = sda_q[1];
    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/cls381_target_model.sv
// I2C target model of the CLS381 colour sensor: config registers, PART_ID,
// STATUS with new-data flag, and a per-transfer snapshot of the colour inputs.
module cls381_target_model
    import cls381_target_model_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h52
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [23:0] data_r,
    input  logic [23:0] data_g,
    input  logic [23:0] data_b,
    input  logic        color_valid,
    output logic [7:0]  main_ctrl,
    output logic [7:0]  meas_rate,
    output logic [7:0]  gain
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .sda_sync  (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_e      state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  main_q, main_d, meas_q, meas_d, gain_q, gain_d;
    logic        rw_q, rw_d, ack_q, ack_d, oe_q, oe_d, new_data_q, new_data_d;
    logic [23:0] snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
    logic        nd_clr;
    logic        byte_done, addr_match;
    logic [7:0]  rd_byte;

    assign byte_done  = (bitcnt_q == 4'd8);
    assign addr_match = (shift_q[7:1] == DEV_ADDR);
    assign rd_byte    = reg_read(ptr_q, main_q, meas_q, gain_q, new_data_q,
                                 snap_r_q, snap_g_q, snap_b_q);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDR;
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR:     if (byte_done) state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: state_d = rw_q ? ST_RD_DATA : ST_PTR;
                ST_PTR:      if (byte_done) state_d = ST_PTR_ACK;
                ST_PTR_ACK:  state_d = ST_WR_DATA;
                ST_WR_DATA:  if (byte_done) state_d = ST_WR_ACK;
                ST_WR_ACK:   state_d = ST_WR_DATA;
                ST_RD_DATA:  if (byte_done) state_d = ST_RD_ACK;
                ST_RD_ACK:   state_d = ack_q ? ST_RD_DATA : ST_IGNORE;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        ptr_d    = ptr_q;
        main_d   = main_q;
        meas_d   = meas_q;
        gain_d   = gain_q;
        rw_d     = rw_q;
        ack_d    = ack_q;
        oe_d     = oe_q;
        snap_r_d = snap_r_q;
        snap_g_d = snap_g_q;
        snap_b_d = snap_b_q;
        nd_clr   = 1'b0;
        if (stop_det || start_det) begin
            oe_d     = 1'b0;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise && !byte_done) begin
                        shift_d  = {shift_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && byte_done) begin
                        if (state_q == ST_ADDR) begin
                            if (addr_match) begin
                                oe_d = 1'b1;
                                rw_d = shift_q[0];
                                if (shift_q[0]) begin
                                    snap_r_d = data_r;
                                    snap_g_d = data_g;
                                    snap_b_d = data_b;
                                end
                            end
                        end else if (state_q == ST_PTR) begin
                            ptr_d = shift_q;
                            oe_d  = 1'b1;
                        end else begin
                            oe_d  = 1'b1;
                            ptr_d = ptr_q + 8'd1;
                            case (ptr_q)
                                ADDR_MAIN_CTRL: main_d = shift_q;
                                ADDR_MEAS_RATE: meas_d = shift_q;
                                ADDR_GAIN:      gain_d = shift_q;
                                default:        ;
                            endcase
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK, ST_RD_ACK: begin
                    if (scl_rise && state_q == ST_RD_ACK) begin
                        ack_d = ~sda_s;
                    end else if (scl_fall) begin
                        bitcnt_d = '0;
                        // Entering a read byte: present its MSB on this same fall.
                        if ((state_q == ST_ADDR_ACK && rw_q) || (state_q == ST_RD_ACK && ack_q)) begin
                            oe_d = ~rd_byte[7];
                            tx_d = {rd_byte[6:0], 1'b0};
                        end else begin
                            oe_d = 1'b0;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise && !byte_done) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            oe_d  = 1'b0;
                            ptr_d = ptr_q + 8'd1;
                            if (ptr_q == ADDR_STATUS) nd_clr = 1'b1;
                        end else begin
                            oe_d = ~tx_q[7];
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
        new_data_d = color_valid | (new_data_q & ~nd_clr);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bitcnt_q   <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            main_q     <= RST_MAIN_CTRL;
            meas_q     <= RST_MEAS_RATE;
            gain_q     <= RST_GAIN;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            new_data_q <= 1'b0;
            snap_r_q   <= '0;
            snap_g_q   <= '0;
            snap_b_q   <= '0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            main_q     <= main_d;
            meas_q     <= meas_d;
            gain_q     <= gain_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
            new_data_q <= new_data_d;
            snap_r_q   <= snap_r_d;
            snap_g_q   <= snap_g_d;
            snap_b_q   <= snap_b_d;
        end
    end

    assign sda_oe    = oe_q;
    assign main_ctrl = main_q;
    assign meas_rate = meas_q;
    assign gain      = gain_q;

endmodule

// File: tb/tb_cls381_target_model.sv
// Bus-master bench for cls381_target_model: drives I2C transactions and
// checks ACKs and read bytes against a scoreboard of expected values.
module tb_cls381_target_model;

    localparam int Q = 100;

    logic        sys_clk, sys_rst, scl, msda, sda_bus, sda_oe, color_valid;
    logic [23:0] data_r, data_g, data_b;
    logic [7:0]  main_ctrl, meas_rate, gain;

    int unsigned n_checks, n_fail;
    bit          mon_en, oe_seen;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    assign sda_bus = msda & ~sda_oe;

    cls381_target_model #(.DEV_ADDR(7'h52)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .scl         (scl),
        .sda_in      (sda_bus),
        .sda_oe      (sda_oe),
        .data_r      (data_r),
        .data_g      (data_g),
        .data_b      (data_b),
        .color_valid (color_valid),
        .main_ctrl   (main_ctrl),
        .meas_rate   (meas_rate),
        .gain        (gain)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The target may only move SDA while SCL is low (reset excepted).
    always @(sda_oe) begin
        if (mon_en && !sys_rst) check_eq("oe_change_scl_low", {31'b0, scl}, 32'd0);
    end
    always @(posedge sda_oe) oe_seen = 1'b1;

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic bus_start();
        msda = 1'b1; #Q;
        scl  = 1'b1; #Q;
        msda = 1'b0; #Q;
        scl  = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        msda = 1'b0; #Q;
        scl  = 1'b1; #Q;
        msda = 1'b1; #Q;
    endtask

    task automatic put_bit(input logic b);
        msda = b; #Q;
        scl  = 1'b1; #(2*Q);
        scl  = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        msda = 1'b1; #Q;
        scl  = 1'b1; #Q;
        b    = sda_bus; #Q;
        scl  = 1'b0; #Q;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        sb_push(tag, {31'b0, exp_ack});
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(a);
        sb_pop_check({31'b0, ~a});
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp, input logic master_ack);
        logic       b;
        logic [7:0] d;
        sb_push(tag, {24'b0, exp});
        d = '0;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        put_bit(~master_ack);
        sb_pop_check({24'b0, d});
    endtask

    initial begin
        logic [7:0] rd_exp [9];
        n_checks = 0; n_fail = 0; mon_en = 0; oe_seen = 0;
        sys_rst = 1'b1; scl = 1'b1; msda = 1'b1; color_valid = 1'b0;
        data_r = '0; data_g = '0; data_b = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_eq("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
        check_eq("rst_main_ctrl", {24'b0, main_ctrl}, 32'h00);
        check_eq("rst_meas_rate", {24'b0, meas_rate}, 32'h22);
        check_eq("rst_gain", {24'b0, gain}, 32'h01);
        mon_en = 1'b1;

        // Burst write with auto-increment.
        bus_start();
        send_byte("wr_addr_ack", 8'hA4, 1'b1);
        send_byte("wr_ptr_ack", 8'h04, 1'b1);
        send_byte("wr_d0_ack", 8'h35, 1'b1);
        send_byte("wr_d1_ack", 8'h66, 1'b1);
        bus_stop();
        check_eq("wr_meas_rate", {24'b0, meas_rate}, 32'h35);
        check_eq("wr_gain", {24'b0, gain}, 32'h66);
        check_eq("wr_main_ctrl", {24'b0, main_ctrl}, 32'h00);

        // Colour burst read; inputs change mid-burst and must not leak in.
        data_g = 24'h123456; data_b = 24'hABCDEF; data_r = 24'h00FF01;
        rd_exp = '{8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h01, 8'hFF, 8'h00};
        bus_start();
        send_byte("col_addr_ack", 8'hA4, 1'b1);
        send_byte("col_ptr_ack", 8'h0D, 1'b1);
        bus_start();
        send_byte("col_raddr_ack", 8'hA5, 1'b1);
        for (int i = 0; i < 9; i++) begin
            recv_byte($sformatf("col_rd%0d", i), rd_exp[i], (i != 8));
            if (i == 1) begin
                data_g = 24'h777777; data_b = 24'h888888; data_r = 24'h999999;
            end
        end
        bus_stop();

        // Foreign address: never acknowledged, SDA never driven.
        oe_seen = 1'b0;
        bus_start();
        send_byte("nak_addr", 8'h52, 1'b0);
        send_byte("nak_ptr", 8'h00, 1'b0);
        send_byte("nak_data", 8'h77, 1'b0);
        bus_stop();
        check_eq("nak_oe_seen", {31'b0, oe_seen}, 32'd0);
        check_eq("nak_main_ctrl", {24'b0, main_ctrl}, 32'h00);
        check_eq("nak_meas_rate", {24'b0, meas_rate}, 32'h35);
        check_eq("nak_gain", {24'b0, gain}, 32'h66);

        // STATUS new_data: set by color_valid, cleared after being read.
        @(negedge sys_clk) color_valid = 1'b1;
        @(negedge sys_clk) color_valid = 1'b0;
        for (int t = 0; t < 2; t++) begin
            bus_start();
            send_byte("st_addr_ack", 8'hA4, 1'b1);
            send_byte("st_ptr_ack", 8'h07, 1'b1);
            bus_start();
            send_byte("st_raddr_ack", 8'hA5, 1'b1);
            recv_byte($sformatf("status_rd%0d", t), (t == 0) ? 8'h08 : 8'h00, 1'b0);
            bus_stop();
        end

        // Writes to read-only PART_ID are acknowledged but dropped.
        bus_start();
        send_byte("ro_addr_ack", 8'hA4, 1'b1);
        send_byte("ro_ptr_ack", 8'h06, 1'b1);
        send_byte("ro_data_ack", 8'h11, 1'b1);
        bus_stop();
        bus_start();
        send_byte("ro_waddr_ack", 8'hA4, 1'b1);
        send_byte("ro_wptr_ack", 8'h06, 1'b1);
        bus_start();
        send_byte("ro_raddr_ack", 8'hA5, 1'b1);
        recv_byte("part_id", 8'hC2, 1'b1);
        recv_byte("status_clear", 8'h00, 1'b0);
        bus_stop();

        // Pointer wrap 0xFF -> 0x00.
        bus_start();
        send_byte("wrap_addr_ack", 8'hA4, 1'b1);
        send_byte("wrap_ptr0_ack", 8'h00, 1'b1);
        send_byte("wrap_main_ack", 8'h5A, 1'b1);
        bus_stop();
        check_eq("wrap_main_ctrl", {24'b0, main_ctrl}, 32'h5A);
        bus_start();
        send_byte("wrap_waddr_ack", 8'hA4, 1'b1);
        send_byte("wrap_ptrff_ack", 8'hFF, 1'b1);
        bus_start();
        send_byte("wrap_raddr_ack", 8'hA5, 1'b1);
        recv_byte("wrap_rd_ff", 8'h00, 1'b1);
        recv_byte("wrap_rd_00", 8'h5A, 1'b0);
        bus_stop();

        // Reset mid-read while the target is pulling SDA low.
        bus_start();
        send_byte("rst_addr_ack", 8'hA4, 1'b1);
        send_byte("rst_ptr_ack", 8'h00, 1'b1);
        bus_start();
        send_byte("rst_raddr_ack", 8'hA5, 1'b1);
        msda = 1'b1; #Q;
        scl  = 1'b1; #Q;
        check_eq("rst_pre_oe", {31'b0, sda_oe}, 32'd1);
        sys_rst = 1'b1;
        #1;
        check_eq("rst_async_oe", {31'b0, sda_oe}, 32'd0);
        #99;
        sys_rst = 1'b0;
        check_eq("rst_mid_main_ctrl", {24'b0, main_ctrl}, 32'h00);
        check_eq("rst_mid_gain", {24'b0, gain}, 32'h01);
        scl = 1'b0; #Q;
        bus_stop();
        bus_start();
        send_byte("post_addr_ack", 8'hA4, 1'b1);
        send_byte("post_ptr_ack", 8'h05, 1'b1);
        send_byte("post_data_ack", 8'h44, 1'b1);
        bus_stop();
        check_eq("post_gain", {24'b0, gain}, 32'h44);
        check_eq("post_meas_rate", {24'b0, meas_rate}, 32'h22);

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
